// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck program loader: FSM state encoding,
// opcode ASCII values, the code terminator and a command-byte classifier.
// No ports; imported by bf_char_filter and bf_program_loader.
package bf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TERM  = 3'd2,
        ST_CRST  = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } bf_state_e;

    localparam logic [7:0] BF_INC        = 8'h2B; // +
    localparam logic [7:0] BF_DEC        = 8'h2D; // -
    localparam logic [7:0] BF_LEFT       = 8'h3C; // <
    localparam logic [7:0] BF_RIGHT      = 8'h3E; // >
    localparam logic [7:0] BF_OPEN       = 8'h5B; // [
    localparam logic [7:0] BF_CLOSE      = 8'h5D; // ]
    localparam logic [7:0] BF_OUT        = 8'h2E; // .
    localparam logic [7:0] BF_IN         = 8'h2C; // ,
    localparam logic [7:0] BF_TERMINATOR = 8'h00;

    function automatic logic is_bf_char(input logic [7:0] ch);
        return (ch == BF_INC)  || (ch == BF_DEC)   ||
               (ch == BF_LEFT) || (ch == BF_RIGHT) ||
               (ch == BF_OPEN) || (ch == BF_CLOSE) ||
               (ch == BF_OUT)  || (ch == BF_IN);
    endfunction

endpackage

// File: rtl/bf_char_filter.sv
// Classifies a received byte as brainfuck command / open bracket / close bracket.
// Latency: purely combinational, zero cycles.
// Backpressure: none; ports rx_data in, is_cmd/is_open/is_close out.
module bf_char_filter
    import bf_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_cmd,
    output logic       is_open,
    output logic       is_close
);

    assign is_cmd   = is_bf_char(rx_data);
    assign is_open  = (rx_data == BF_OPEN);
    assign is_close = (rx_data == BF_CLOSE);

endmodule

// File: rtl/bf_program_loader.sv
// Loads filtered UART bytes into code memory, checks bracket balance, then
// resets and runs the core. Latency: writes appear one cycle after rx_valid;
// core_run rises 2+RST_CYCLES cycles after loading falls. No backpressure:
// rx bytes are accepted or dropped the cycle they are strobed.
// Ports: clk/reset (async active-low), loading, rx_valid/rx_data, core_done in;
// code_we/code_addr/code_wdata, core_reset/core_run, prog_len, overflow,
// bracket_err, state out. All outputs are registered.
module bf_program_loader
    import bf_pkg::*;
#(
    parameter int CODE_ADDR_WIDTH = 9,
    parameter int RST_CYCLES      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       loading,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    input  logic                       core_done,
    output logic                       code_we,
    output logic [CODE_ADDR_WIDTH-1:0] code_addr,
    output logic [7:0]                 code_wdata,
    output logic                       core_reset,
    output logic                       core_run,
    output logic [CODE_ADDR_WIDTH-1:0] prog_len,
    output logic                       overflow,
    output logic                       bracket_err,
    output logic [2:0]                 state
);

    localparam int DEPTH_W = CODE_ADDR_WIDTH + 1;
    localparam int CNT_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    // Last slot is kept free for the terminator.
    localparam logic [CODE_ADDR_WIDTH-1:0] PROG_MAX = '1;

    bf_state_e                  state_q;
    logic                       loading_q;
    logic                       code_we_q;
    logic [CODE_ADDR_WIDTH-1:0] code_addr_q;
    logic [7:0]                 code_wdata_q;
    logic                       core_reset_q;
    logic                       core_run_q;
    logic [CODE_ADDR_WIDTH-1:0] prog_len_q;
    logic                       overflow_q;
    logic                       bracket_err_q;
    logic [DEPTH_W-1:0]         depth_q;
    logic [CNT_W-1:0]           rst_cnt_q;

    logic is_cmd, is_open, is_close;
    logic load_rise_d;

    bf_char_filter u_filter (
        .rx_data  (rx_data),
        .is_cmd   (is_cmd),
        .is_open  (is_open),
        .is_close (is_close)
    );

    assign load_rise_d = loading && !loading_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            loading_q     <= 1'b0;
            code_we_q     <= 1'b0;
            code_addr_q   <= '0;
            code_wdata_q  <= '0;
            core_reset_q  <= 1'b0;
            core_run_q    <= 1'b0;
            prog_len_q    <= '0;
            overflow_q    <= 1'b0;
            bracket_err_q <= 1'b0;
            depth_q       <= '0;
            rst_cnt_q     <= '0;
        end else begin
            loading_q <= loading;
            code_we_q <= 1'b0;
            if (load_rise_d) begin
                // A new load aborts whatever was running.
                state_q       <= ST_LOAD;
                prog_len_q    <= '0;
                overflow_q    <= 1'b0;
                bracket_err_q <= 1'b0;
                depth_q       <= '0;
                core_run_q    <= 1'b0;
                core_reset_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_LOAD: begin
                        if (rx_valid && is_cmd) begin
                            if (is_close && (depth_q == '0)) begin
                                bracket_err_q <= 1'b1;
                            end else if (prog_len_q == PROG_MAX) begin
                                overflow_q <= 1'b1;
                            end else begin
                                code_we_q    <= 1'b1;
                                code_addr_q  <= prog_len_q;
                                code_wdata_q <= rx_data;
                                prog_len_q   <= prog_len_q + CODE_ADDR_WIDTH'(1);
                                if (is_open) begin
                                    depth_q <= depth_q + DEPTH_W'(1);
                                end else if (is_close) begin
                                    depth_q <= depth_q - DEPTH_W'(1);
                                end
                            end
                        end
                        // A byte arriving with the falling edge is still taken
                        // above, so the terminator lands after it.
                        if (!loading) begin
                            state_q <= ST_TERM;
                        end
                    end
                    ST_TERM: begin
                        code_we_q    <= 1'b1;
                        code_addr_q  <= prog_len_q;
                        code_wdata_q <= BF_TERMINATOR;
                        if (bracket_err_q || overflow_q || (depth_q != '0)) begin
                            state_q <= ST_ERROR;
                            if (depth_q != '0) begin
                                bracket_err_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= ST_CRST;
                            rst_cnt_q <= '0;
                        end
                    end
                    ST_CRST: begin
                        if (rst_cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                            state_q      <= ST_RUN;
                            core_reset_q <= 1'b1;
                            core_run_q   <= 1'b1;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (core_done) begin
                            state_q    <= ST_DONE;
                            core_run_q <= 1'b0;
                        end
                    end
                    ST_DONE, ST_ERROR: begin
                        core_run_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign code_we     = code_we_q;
    assign code_addr   = code_addr_q;
    assign code_wdata  = code_wdata_q;
    assign core_reset  = core_reset_q;
    assign core_run    = core_run_q;
    assign prog_len    = prog_len_q;
    assign overflow    = overflow_q;
    assign bracket_err = bracket_err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Self-checking bench for bf_program_loader with a small code memory (8 slots).
// Directed scenarios followed by random programs, checked against a reference model.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_bf_program_loader;
    import bf_pkg::*;

    localparam int AW = 3;
    localparam int RC = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          loading   = 1'b0;
    logic          rx_valid  = 1'b0;
    logic [7:0]    rx_data   = 8'h00;
    logic          core_done = 1'b0;
    logic          code_we;
    logic [AW-1:0] code_addr;
    logic [7:0]    code_wdata;
    logic          core_reset;
    logic          core_run;
    logic [AW-1:0] prog_len;
    logic          overflow;
    logic          bracket_err;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] stim[$];

    // Reference model state for the program being loaded.
    int m_len;
    int m_depth;
    bit m_ovf;
    bit m_berr;

    bf_program_loader #(
        .CODE_ADDR_WIDTH (AW),
        .RST_CYCLES      (RC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .loading     (loading),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .core_done   (core_done),
        .code_we     (code_we),
        .code_addr   (code_addr),
        .code_wdata  (code_wdata),
        .core_reset  (core_reset),
        .core_run    (core_run),
        .prog_len    (prog_len),
        .overflow    (overflow),
        .bracket_err (bracket_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every cycle in which the write strobe is high.
    always @(posedge clk) begin
        #1;
        if (code_we === 1'b1) begin
            got_q.push_back(wr_t'{int'(code_addr), int'(code_wdata), cyc});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_stim(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    // Applies the loading rules to one strobed byte at the program level.
    task automatic model_byte(input logic [7:0] b, input int drive_cyc);
        string cmds;
        bit    is_cmd;
        cmds   = "+-<>[].,";
        is_cmd = 1'b0;
        for (int i = 0; i < cmds.len(); i++) if (cmds[i] == b) is_cmd = 1'b1;
        if (!is_cmd) return;
        if (b == "]" && m_depth == 0) begin
            m_berr = 1'b1;
            return;
        end
        if (m_len == (1 << AW) - 1) begin
            m_ovf = 1'b1;
            return;
        end
        exp_q.push_back(wr_t'{m_len, int'(b), drive_cyc + 1});
        m_len++;
        if (b == "[") m_depth++;
        else if (b == "]") m_depth--;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"},    code_we, 0);
        chk({tag, "_addr"},  code_addr, 0);
        chk({tag, "_wdata"}, code_wdata, 0);
        chk({tag, "_crst"},  core_reset, 0);
        chk({tag, "_run"},   core_run, 0);
        chk({tag, "_len"},   prog_len, 0);
        chk({tag, "_ovf"},   overflow, 0);
        chk({tag, "_berr"},  bracket_err, 0);
        chk({tag, "_state"}, state, ST_IDLE);
    endtask

    // Loads stim, checks terminator and start-up; ran=1 if the core reached RUN.
    task automatic do_prog(input bit coincide, output bit ran);
        int low;
        bit last;
        ran = 1'b0;
        @(negedge clk);
        loading = 1'b1;
        @(negedge clk);
        chk("rise_state", state, ST_LOAD);
        chk("rise_len",   prog_len, 0);
        chk("rise_ovf",   overflow, 0);
        chk("rise_berr",  bracket_err, 0);
        chk("rise_run",   core_run, 0);
        chk("rise_crst",  core_reset, 0);
        m_len = 0; m_depth = 0; m_ovf = 1'b0; m_berr = 1'b0;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < stim.size(); i++) begin
            last     = coincide && (i == stim.size() - 1);
            rx_valid = 1'b1;
            rx_data  = stim[i];
            model_byte(stim[i], cyc);
            if (last) loading = 1'b0;
            @(negedge clk);
            rx_valid = 1'b0;
            chk("byte_len",  prog_len, m_len);
            chk("byte_ovf",  overflow, m_ovf);
            chk("byte_berr", bracket_err, m_berr);
            if (!last) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        if (!coincide) begin
            loading = 1'b0;
            @(negedge clk);
        end
        chk("term_state", state, ST_TERM);
        @(negedge clk);
        chk("term_we",    code_we, 1);
        chk("term_addr",  code_addr, m_len);
        chk("term_data",  code_wdata, 0);
        exp_q.push_back(wr_t'{m_len, 0, cyc});
        if (m_berr || m_ovf || m_depth != 0) begin
            chk("err_state", state, ST_ERROR);
            chk("err_berr",  bracket_err, (m_berr || m_depth != 0));
            chk("err_ovf",   overflow, m_ovf);
            repeat (3) begin
                @(negedge clk);
                chk("err_run",  core_run, 0);
                chk("err_crst", core_reset, 0);
            end
            chk("err_hold", state, ST_ERROR);
        end else begin
            low = 0;
            while (core_run !== 1'b1 && low < 20) begin
                if (core_reset === 1'b0) low++;
                @(negedge clk);
            end
            chk("crst_cycles", low, RC);
            chk("run_crst",    core_reset, 1);
            chk("run_state",   state, ST_RUN);
            ran = 1'b1;
        end
        chk("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("wr_addr", got_q[i].addr, exp_q[i].addr);
            chk("wr_data", got_q[i].data, exp_q[i].data);
            chk("wr_cyc",  got_q[i].cyc,  exp_q[i].cyc);
        end
    endtask

    task automatic run_done(input int k);
        repeat (k) begin
            @(negedge clk);
            chk("run_hold", core_run, 1);
        end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("done_state", state, ST_DONE);
        chk("done_run",   core_run, 0);
        chk("done_crst",  core_reset, 1);
        @(negedge clk);
        chk("done_hold",  state, ST_DONE);
    endtask

    initial begin
        bit    ran;
        bit    co;
        int    n;
        string alpha;
        alpha = "+-<>[].,x \n";

        // Reset state.
        #1 reset = 1'b0;
        #2 check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_state", state, ST_IDLE);
        chk("idle_crst",  core_reset, 0);

        // Basic load and run.
        set_stim("+[-].");
        do_prog(1'b0, ran);
        chk("basic_len", prog_len, 5);
        if (ran) run_done(3);

        // Filtering.
        set_stim("a+\n b-");
        do_prog(1'b0, ran);
        chk("filter_len", prog_len, 2);
        if (ran) run_done(1);

        // Close bracket at depth zero, then unclosed brackets.
        set_stim("]+");
        do_prog(1'b0, ran);
        chk("close0_ran", ran, 0);
        set_stim("[[+]");
        do_prog(1'b0, ran);
        chk("open_ran", ran, 0);

        // Overflow with 8-slot memory.
        set_stim("+++++++++");
        do_prog(1'b0, ran);
        chk("ovf_flag", overflow, 1);
        chk("ovf_len",  prog_len, 7);

        // Byte strobed as loading falls.
        set_stim("+.");
        do_prog(1'b1, ran);
        chk("coinc_len", prog_len, 2);
        if (ran) run_done(2);

        // Asynchronous reset during RUN.
        set_stim("+");
        do_prog(1'b0, ran);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_idle", state, ST_IDLE);

        // New load while running.
        set_stim("+-");
        do_prog(1'b0, ran);
        chk("prerise_ran", ran, 1);
        set_stim("<>,");
        do_prog(1'b0, ran);
        if (ran) run_done(1);

        // Random programs.
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 10);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
            co = (n > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_prog(co, ran);
            if (ran) run_done($urandom_range(0, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
